aurora_tx_lane_scheduler: RTL

- Per-lane transmit scheduler that drives the 8-bit ToSend request vector of the Aurora 64b/66b multilane priority mux and consumes its Sent feedback.
- Sequences lane bring-up (Not-Ready, then Channel-Bonding blocks) and then runs the lane.
- In run state it injects periodic Clock-Compensation bursts and forwards user data, K-block and flow-control requests.
- Returns one-cycle acknowledges to requesters.

---
 rtl/aurora_tx_pkg.sv | 26 ++
 rtl/aurora_cc_timer.sv | 84 ++++++++
 rtl/aurora_tx_lane_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared definitions for the Aurora 64b/66b transmit lane scheduler.
// ToSend bit indices match the multilane priority mux: a higher index wins.
package aurora_tx_pkg;

  localparam int IDLE                = 0;
  localparam int USER_DATA           = 1;
  localparam int USER_KBLOCKS        = 2;
  localparam int USER_FLOW_CONTROL   = 3;
  localparam int NATIVE_FLOW_CONTROL = 4;
  localparam int CHANNEL_BONDING     = 5;
  localparam int NOT_READY           = 6;
  localparam int CLOCK_COMPENSATION  = 7;

  typedef enum logic [1:0] {
    LS_IDLE      = 2'd0,
    LS_NOT_READY = 2'd1,
    LS_BONDING   = 2'd2,
    LS_RUN       = 2'd3
  } lane_state_t;

  // One-hot request mask for a ToSend bit index.
  function automatic logic [7:0] bit_mask(input int idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation timer: interval counter over block slots plus the
// burst counter that retires CC blocks as the mux accepts them.
module aurora_cc_timer
  import aurora_tx_pkg::*;
#(
  parameter int CC_INTERVAL = 5000,
  parameter int CC_BURST    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic slot_i,
  input  logic cc_sent_i,
  input  logic run_i,
  output logic cc_pending_o
);

  localparam int IW = $clog2(CC_INTERVAL);
  localparam int BW = (CC_BURST > 1) ? $clog2(CC_BURST) : 1;
  localparam logic [IW-1:0] INT_LAST   = IW'(CC_INTERVAL - 1);
  localparam logic [IW-1:0] INT_PRE    = IW'(CC_INTERVAL - 2);
  localparam logic [IW-1:0] INT_ONE    = IW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(CC_BURST - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);

  logic [IW-1:0] int_q, int_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          pend_q, pend_d;
  logic          expire_s;

  // Next-state: interval wrap, expiry detection and burst retirement; all cleared outside RUN.
  always_comb begin
    int_d    = int_q;
    burst_d  = burst_q;
    pend_d   = pend_q;
    expire_s = 1'b0;
    if (!run_i) begin
      int_d   = '0;
      burst_d = '0;
      pend_d  = 1'b0;
    end else begin
      // Expiry is the slot that brings the interval counter to its last value.
      expire_s = slot_i && (int_q == INT_PRE);
      if (slot_i) begin
        if (int_q == INT_LAST) begin
          int_d = '0;
        end else begin
          int_d = int_q + INT_ONE;
        end
      end else begin
        int_d = int_q;
      end
      if (cc_sent_i && pend_q) begin
        if (burst_q == BURST_LAST) begin
          // Burst complete; an expiry on this very slot starts a fresh burst.
          burst_d = '0;
          pend_d  = expire_s;
        end else begin
          burst_d = burst_q + BURST_ONE;
          pend_d  = 1'b1;
        end
      end else begin
        // An expiry during a pending burst merges into it and is not queued.
        burst_d = burst_q;
        pend_d  = pend_q | expire_s;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_q   <= '0;
      burst_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      int_q   <= int_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
    end
  end

  assign cc_pending_o = pend_q;

endmodule

// File: rtl/aurora_tx_lane_scheduler.sv
// Per-lane transmit scheduler: lane bring-up (Not-Ready, Channel-Bonding),
// then run with periodic CC bursts and user request forwarding to the mux.
module aurora_tx_lane_scheduler
  import aurora_tx_pkg::*;
#(
  parameter int CC_INTERVAL = 5000,
  parameter int CC_BURST    = 3,
  parameter int NR_COUNT    = 64,
  parameter int CB_COUNT    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] sent_i,
  input  logic       data_req_i,
  input  logic       userk_req_i,
  input  logic       nfc_req_i,
  input  logic       ufc_req_i,
  output logic [7:0] to_send_o,
  output logic       data_ack_o,
  output logic       userk_ack_o,
  output logic       nfc_ack_o,
  output logic       ufc_ack_o,
  output logic [1:0] lane_state_o,
  output logic       cc_pending_o
);

  localparam int NR_W = (NR_COUNT > 1) ? $clog2(NR_COUNT) : 1;
  localparam int CB_W = (CB_COUNT > 1) ? $clog2(CB_COUNT) : 1;
  localparam int CW   = (NR_W > CB_W) ? NR_W : CB_W;
  localparam logic [CW-1:0] NR_LAST = CW'(NR_COUNT - 1);
  localparam logic [CW-1:0] CB_LAST = CW'(CB_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  lane_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    to_send_s;
  logic          run_s;
  logic          cc_pending_s;

  // Lane FSM next-state: bring-up counts advance only on their own Sent bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_i) begin
      state_d = LS_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LS_IDLE: begin
          state_d = LS_NOT_READY;
          cnt_d   = '0;
        end
        LS_NOT_READY: begin
          if (sent_i[NOT_READY]) begin
            if (cnt_q == NR_LAST) begin
              state_d = LS_BONDING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        LS_BONDING: begin
          if (sent_i[CHANNEL_BONDING]) begin
            if (cnt_q == CB_LAST) begin
              state_d = LS_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        LS_RUN: begin
          state_d = LS_RUN;
          cnt_d   = '0;
        end
        default: begin
          state_d = LS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Lane FSM state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run_s = (state_q == LS_RUN) && enable_i;

  aurora_cc_timer #(
    .CC_INTERVAL (CC_INTERVAL),
    .CC_BURST    (CC_BURST)
  ) u_cc_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .slot_i       (|sent_i),
    .cc_sent_i    (sent_i[CLOCK_COMPENSATION]),
    .run_i        (run_s),
    .cc_pending_o (cc_pending_s)
  );

  // Request vector: IDLE always offered; user requests only pass in RUN.
  always_comb begin
    to_send_s = bit_mask(IDLE);
    case (state_q)
      LS_IDLE: begin
        to_send_s = bit_mask(IDLE);
      end
      LS_NOT_READY: begin
        to_send_s = bit_mask(IDLE) | bit_mask(NOT_READY);
      end
      LS_BONDING: begin
        to_send_s = bit_mask(IDLE) | bit_mask(CHANNEL_BONDING);
      end
      LS_RUN: begin
        to_send_s[USER_DATA]           = data_req_i;
        to_send_s[USER_KBLOCKS]        = userk_req_i;
        to_send_s[NATIVE_FLOW_CONTROL] = nfc_req_i;
        to_send_s[USER_FLOW_CONTROL]   = ufc_req_i;
        to_send_s[CLOCK_COMPENSATION]  = cc_pending_s;
      end
      default: begin
        to_send_s = bit_mask(IDLE);
      end
    endcase
  end

  assign to_send_o    = to_send_s;
  assign data_ack_o   = sent_i[USER_DATA]           && (state_q == LS_RUN);
  assign userk_ack_o  = sent_i[USER_KBLOCKS]        && (state_q == LS_RUN);
  assign nfc_ack_o    = sent_i[NATIVE_FLOW_CONTROL] && (state_q == LS_RUN);
  assign ufc_ack_o    = sent_i[USER_FLOW_CONTROL]   && (state_q == LS_RUN);
  assign lane_state_o = state_q;
  assign cc_pending_o = cc_pending_s;

endmodule
